fb_scanout: RTL and testbench

//  Read-side counterpart of the pixel fetch/scale engine. That engine writes a 256x256 frame into

---
 rtl/fb_scanout_if.sv | 39 +++
 rtl/fb_scanout.sv | 170 +++++++++++++++++
 tb/tb_fb_scanout.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// fb_scanout_if
//  Groups the frame-scanout signals: start/base control, the shared image
//  memory (IM) read bus, the output pixel stream and the status flags.
//  Modports:
//   master : the scanout engine (drives Bus_Req, IM_A, IM_WEN, Pix_*, Busy, Frame_Done)
//   slave  : the environment (drives Start, FB_Addr, Bus_Gnt, IM_Q, Pix_Ready)
interface fb_scanout_if #(
    parameter int DATASIZE = 24,
    parameter int ADDRSIZE = 20
);
    logic                Start;
    logic [ADDRSIZE-1:0] FB_Addr;
    logic                Bus_Req;
    logic                Bus_Gnt;
    logic [ADDRSIZE-1:0] IM_A;
    logic                IM_WEN;
    logic [DATASIZE-1:0] IM_Q;
    logic [DATASIZE-1:0] Pix_Data;
    logic [7:0]          Pix_X;
    logic [7:0]          Pix_Y;
    logic                Pix_SOF;
    logic                Pix_EOL;
    logic                Pix_Valid;
    logic                Pix_Ready;
    logic                Busy;
    logic                Frame_Done;

    modport master (
        input  Start, FB_Addr, Bus_Gnt, IM_Q, Pix_Ready,
        output Bus_Req, IM_A, IM_WEN, Pix_Data, Pix_X, Pix_Y,
               Pix_SOF, Pix_EOL, Pix_Valid, Busy, Frame_Done
    );

    modport slave (
        output Start, FB_Addr, Bus_Gnt, IM_Q, Pix_Ready,
        input  Bus_Req, IM_A, IM_WEN, Pix_Data, Pix_X, Pix_Y,
               Pix_SOF, Pix_EOL, Pix_Valid, Busy, Frame_Done
    );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout
//  Reads a 256x256 frame back out of image memory (IM) in raster order and
//  delivers it as a valid/ready pixel stream. The IM bus is shared, so reads
//  are only issued while the bus is granted; a small FIFO absorbs the one-cycle
//  read latency and downstream backpressure.
//  Ports:
//   clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : fb_scanout_if.master -- Start/FB_Addr control, IM read bus
//              (Bus_Req/Bus_Gnt/IM_A/IM_WEN/IM_Q), pixel stream
//              (Pix_Data/X/Y/SOF/EOL/Valid/Ready), Busy and Frame_Done status
module fb_scanout #(
    parameter int DATASIZE   = 24,
    parameter int ADDRSIZE   = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          Reset_n,
    fb_scanout_if.master  bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDRSIZE-1:0] base;
    logic [7:0]          x, y;
    logic [ADDRSIZE-1:0] im_a;

    // vld_p0: read address on IM_A this cycle; vld_p1: IM_Q valid this cycle
    logic                vld_p0, vld_p1;
    logic [7:0]          x_p0, y_p0, x_p1, y_p1;

    logic [DATASIZE-1:0] fifo_data [FIFO_DEPTH];
    logic [7:0]          fifo_x    [FIFO_DEPTH];
    logic [7:0]          fifo_y    [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

    logic                start_acc, issue, bus_req;
    logic                last_pix, drained, fifo_empty, push, pop;
    logic [OW-1:0]       occupancy;

    always_comb begin
        fifo_empty = (count == '0);
        push       = vld_p1;
        pop        = !fifo_empty && bus.Pix_Ready;
        last_pix   = (x == 8'hFF) && (y == 8'hFF);
        drained    = fifo_empty && !vld_p0 && !vld_p1;
        // Reads still in the pipeline will land in the FIFO, so they count
        // against its free space before another read may go out.
        occupancy  = OW'(count) + OW'(vld_p0) + OW'(vld_p1);
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        issue     = 1'b0;
        bus_req   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    start_acc = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus.Bus_Gnt) state_nxt = FETCH;
            end
            FETCH: begin
                bus_req = 1'b1;
                if (!bus.Bus_Gnt) begin
                    state_nxt = REQ;
                end else if (occupancy < OW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (last_pix) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                bus_req = vld_p0 || vld_p1;
                if (drained) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x      <= 8'd0;
            y      <= 8'd0;
            im_a   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (start_acc)  {y, x} <= 16'd0;
            else if (issue) {y, x} <= {y, x} + 16'd1;

            // Address add is ADDRSIZE wide and simply wraps; no carry out.
            if (issue) im_a <= base + ADDRSIZE'({y, x});

            vld_p0 <= issue;
            vld_p1 <= vld_p0;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // p0 -> p1: coordinates follow the read through the IM latency
    always_ff @(posedge clk) begin
        if (start_acc) base <= bus.FB_Addr;
        if (issue) begin
            x_p0 <= x;
            y_p0 <= y;
        end
        x_p1 <= x_p0;
        y_p1 <= y_p0;
        // p1 -> FIFO: IM_Q captured with its coordinates
        if (push) begin
            fifo_data[wr_ptr] <= bus.IM_Q;
            fifo_x[wr_ptr]    <= x_p1;
            fifo_y[wr_ptr]    <= y_p1;
        end
    end

    // Outputs are forced to zero while the FIFO is empty so the stream reads
    // as all-zero after reset without resetting the FIFO storage.
    assign bus.Bus_Req    = bus_req;
    assign bus.IM_A       = im_a;
    assign bus.IM_WEN     = 1'b1;
    assign bus.Pix_Valid  = !fifo_empty;
    assign bus.Pix_Data   = fifo_empty ? '0   : fifo_data[rd_ptr];
    assign bus.Pix_X      = fifo_empty ? 8'd0 : fifo_x[rd_ptr];
    assign bus.Pix_Y      = fifo_empty ? 8'd0 : fifo_y[rd_ptr];
    assign bus.Pix_SOF    = !fifo_empty && (fifo_x[rd_ptr] == 8'd0) && (fifo_y[rd_ptr] == 8'd0);
    assign bus.Pix_EOL    = !fifo_empty && (fifo_x[rd_ptr] == 8'hFF);
    assign bus.Busy       = (state != IDLE);
    assign bus.Frame_Done = (state == DONE);

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    localparam int DW    = 24;
    localparam int AW    = 20;
    localparam int DEPTH = 4;
    localparam int FRAME = 65536;

    logic clk = 1'b0;
    logic Reset_n;
    always #5 clk = ~clk;

    fb_scanout_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    fb_scanout #(.DATASIZE(DW), .ADDRSIZE(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Image memory: each word holds its own address, read data one cycle later.
    always @(posedge clk) bus.IM_Q <= {4'h0, bus.IM_A};

    typedef struct {
        logic [19:0] fb_addr;
        int          ready_pct;
        int          gnt_drop_n;   // pixel index whose issue triggers a 5-cycle grant drop (-1: none)
        int          start_ign_n;  // after this many transfers pulse Start with another base (-1: none)
        int          stop_n;       // transfers before a mid-frame reset (FRAME: run to completion)
        int          exp_pixels;
        int          exp_sof;
        int          exp_eol;
        int          exp_done;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [19:0] exp_addr(input logic [19:0] b, input int n);
        return b + 20'(n);
    endfunction

    function automatic logic [23:0] exp_data(input logic [19:0] b, input int n);
        return {4'h0, exp_addr(b, n)};
    endfunction

    // Monitor state
    bit          mon_en = 1'b0;
    logic [19:0] cur_base;
    logic [19:0] last_im_a;
    logic [41:0] held;
    logic [23:0] pix256;
    bit          gnt_prev, stalled_prev;
    int cyc, issued, xfer, max_out, addr_err, gnt_err, req_err, order_err, stall_err;
    int wen_err, busy_err, sof_cnt, eol_cnt, done_cnt, done_xfer;
    int first_issue_cyc, first_valid_cyc, vrun, max_vrun;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (bus.IM_WEN !== 1'b1) wen_err++;
            if (bus.IM_A !== last_im_a) begin
                if (!gnt_prev) gnt_err++;
                if (bus.Bus_Req !== 1'b1) req_err++;
                if (bus.IM_A === exp_addr(cur_base, issued)) begin
                    issued++;
                    if (issued == 1) first_issue_cyc = cyc;
                end else begin
                    addr_err++;
                end
                last_im_a = bus.IM_A;
            end
            if (issued - xfer > max_out) max_out = issued - xfer;
            if (stalled_prev && (!bus.Pix_Valid ||
                {bus.Pix_Data, bus.Pix_X, bus.Pix_Y, bus.Pix_SOF, bus.Pix_EOL} !== held))
                stall_err++;
            if (bus.Pix_Valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                vrun++;
                if (vrun > max_vrun) max_vrun = vrun;
            end else begin
                vrun = 0;
            end
            if (bus.Pix_Valid && bus.Pix_Ready) begin
                if (bus.Pix_Data !== exp_data(cur_base, xfer) ||
                    bus.Pix_X !== 8'(xfer) || bus.Pix_Y !== 8'(xfer >> 8) ||
                    bus.Pix_SOF !== (xfer == 0) || bus.Pix_EOL !== (8'(xfer) == 8'hFF))
                    order_err++;
                if (xfer == 256) pix256 = bus.Pix_Data;
                if (bus.Pix_SOF) sof_cnt++;
                if (bus.Pix_EOL) eol_cnt++;
                xfer++;
            end
            stalled_prev = bus.Pix_Valid && !bus.Pix_Ready;
            held = {bus.Pix_Data, bus.Pix_X, bus.Pix_Y, bus.Pix_SOF, bus.Pix_EOL};
            if (done_cnt == 0 && !bus.Busy) busy_err++;
            if (bus.Frame_Done) begin
                done_cnt++;
                done_xfer = xfer;
            end
            gnt_prev = bus.Bus_Gnt;
        end
    end

    task automatic rst_check(input string tag);
        chk({tag, "_IM_A"},       bus.IM_A,       0);
        chk({tag, "_IM_WEN"},     bus.IM_WEN,     1);
        chk({tag, "_Bus_Req"},    bus.Bus_Req,    0);
        chk({tag, "_Pix_Valid"},  bus.Pix_Valid,  0);
        chk({tag, "_Pix_Data"},   bus.Pix_Data,   0);
        chk({tag, "_Pix_X"},      bus.Pix_X,      0);
        chk({tag, "_Pix_Y"},      bus.Pix_Y,      0);
        chk({tag, "_SOF_EOL"},    {bus.Pix_SOF, bus.Pix_EOL}, 0);
        chk({tag, "_Busy"},       bus.Busy,       0);
        chk({tag, "_Frame_Done"}, bus.Frame_Done, 0);
    endtask

    task automatic run_row(input int r);
        vec_t        v;
        string       t;
        int          budget, drop_left;
        bit          dropped, resume_checked, ign_done, finished, fd_seen, busy_seen;
        logic [19:0] frozen;
        v = vecs[r];
        t = $sformatf("r%0d", r);
        dropped = 0; resume_checked = 0; ign_done = 0; finished = 0; drop_left = 0;
        frozen = '0;

        @(posedge clk); #1;
        Reset_n = 1'b0;
        bus.Start = 1'b0; bus.Bus_Gnt = 1'b0; bus.Pix_Ready = 1'b0;
        #1;
        rst_check({t, "_rst"});
        repeat (2) @(posedge clk);
        #1 Reset_n = 1'b1;

        cur_base = v.fb_addr; last_im_a = '0; held = '0; pix256 = '0;
        gnt_prev = 0; stalled_prev = 0;
        cyc = 0; issued = 0; xfer = 0; max_out = 0; addr_err = 0; gnt_err = 0; req_err = 0;
        order_err = 0; stall_err = 0; wen_err = 0; busy_err = 0; sof_cnt = 0; eol_cnt = 0;
        done_cnt = 0; done_xfer = 0; first_issue_cyc = -1; first_valid_cyc = -1;
        vrun = 0; max_vrun = 0;

        @(posedge clk); #1;
        bus.FB_Addr   = v.fb_addr;
        bus.Start     = 1'b1;
        bus.Bus_Gnt   = 1'b1;
        bus.Pix_Ready = ($urandom_range(99) < v.ready_pct);
        @(posedge clk); #1;
        bus.Start   = 1'b0;
        bus.FB_Addr = 20'($urandom);
        chk({t, "_busy_after_start"}, bus.Busy, 1);
        chk({t, "_req_after_start"},  bus.Bus_Req, 1);
        mon_en = 1'b1;

        budget = (v.ready_pct >= 100) ? v.stop_n + 1000 : (v.stop_n * 100) / v.ready_pct + 2000;
        for (int c = 0; c < budget && !finished; c++) begin
            if (v.stop_n < FRAME && xfer >= v.stop_n) begin
                finished = 1;
            end else if (done_cnt > 0) begin
                finished = 1;
            end else begin
                bus.Pix_Ready = ($urandom_range(99) < v.ready_pct);
                if (drop_left > 0) begin
                    bus.Bus_Gnt = 1'b0;
                    drop_left--;
                end else begin
                    if (dropped && !resume_checked) begin
                        chk({t, "_im_a_frozen"}, bus.IM_A, frozen);
                        resume_checked = 1;
                    end
                    bus.Bus_Gnt = 1'b1;
                    if (!dropped && v.gnt_drop_n >= 0 &&
                        bus.IM_A === exp_addr(v.fb_addr, v.gnt_drop_n)) begin
                        dropped     = 1;
                        frozen      = bus.IM_A;
                        bus.Bus_Gnt = 1'b0;
                        drop_left   = 4;
                    end
                end
                if (!ign_done && v.start_ign_n >= 0 && xfer >= v.start_ign_n) begin
                    bus.Start   = 1'b1;
                    bus.FB_Addr = v.fb_addr ^ 20'h5A5A5;
                    ign_done    = 1;
                end else begin
                    bus.Start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        mon_en    = 1'b0;
        bus.Start = 1'b0;
        chk({t, "_finished_in_budget"}, finished, 1);

        if (v.stop_n < FRAME) begin
            Reset_n = 1'b0;
            #1;
            rst_check({t, "_abort"});
            @(negedge clk);
            Reset_n = 1'b1;
            fd_seen = 0; busy_seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.Frame_Done) fd_seen = 1;
                if (bus.Busy) busy_seen = 1;
            end
            chk({t, "_no_done_after_abort"}, fd_seen, 0);
            chk({t, "_idle_after_abort"},    busy_seen, 0);
        end else begin
            chk({t, "_busy_low_after_done"}, bus.Busy, 0);
            chk({t, "_done_one_cycle"},      bus.Frame_Done, 0);
            chk({t, "_done_after_last"},     done_xfer, FRAME);
        end

        chk({t, "_pixels"},     xfer,      v.exp_pixels);
        chk({t, "_sof_count"},  sof_cnt,   v.exp_sof);
        chk({t, "_eol_count"},  eol_cnt,   v.exp_eol);
        chk({t, "_done_count"}, done_cnt,  v.exp_done);
        chk({t, "_order_err"},  order_err, 0);
        chk({t, "_stall_err"},  stall_err, 0);
        chk({t, "_addr_err"},   addr_err,  0);
        chk({t, "_issue_without_gnt"}, gnt_err, 0);
        chk({t, "_issue_without_req"}, req_err, 0);
        chk({t, "_wen_err"},    wen_err,   0);
        chk({t, "_busy_err"},   busy_err,  0);
        chk({t, "_outstanding_le_depth"}, (max_out <= DEPTH), 1);
        chk({t, "_first_valid_latency"},  first_valid_cyc - first_issue_cyc, 2);
        if (v.gnt_drop_n >= 0)  chk({t, "_gnt_drop_hit"},   resume_checked, 1);
        if (v.start_ign_n >= 0) chk({t, "_start_pulsed"},   ign_done, 1);
        if (v.stop_n == FRAME && v.ready_pct == 100 && v.gnt_drop_n < 0)
            chk({t, "_consecutive_valid"}, max_vrun, FRAME);
        if (v.fb_addr == 20'hFFF00) chk({t, "_wrap_at_0_1"}, pix256, 0);
    endtask

    initial begin
        Reset_n       = 1'b0;
        bus.Start     = 1'b0;
        bus.FB_Addr   = '0;
        bus.Bus_Gnt   = 1'b0;
        bus.Pix_Ready = 1'b0;

        vecs[0] = '{fb_addr: 20'h10000, ready_pct: 50,  gnt_drop_n: -1,    start_ign_n: -1,
                    stop_n: 'h300, exp_pixels: 'h300, exp_sof: 1, exp_eol: 3, exp_done: 0};
        vecs[1] = '{fb_addr: 20'h23456, ready_pct: 100, gnt_drop_n: 'h364, start_ign_n: -1,
                    stop_n: 'h400, exp_pixels: 'h400, exp_sof: 1, exp_eol: 4, exp_done: 0};
        vecs[2] = '{fb_addr: 20'hABCDE, ready_pct: 70,  gnt_drop_n: 'h364, start_ign_n: 'h50,
                    stop_n: 'h480, exp_pixels: 'h480, exp_sof: 1, exp_eol: 4, exp_done: 0};
        vecs[3] = '{fb_addr: 20'hFFF00, ready_pct: 100, gnt_drop_n: -1,    start_ign_n: 'h8000,
                    stop_n: FRAME, exp_pixels: FRAME, exp_sof: 1, exp_eol: 256, exp_done: 1};

        for (int r = 0; r < 4; r++) run_row(r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
